// File: rtl/xadc_pkg.sv
// Shared types and constants for the XADC auxiliary-channel scan sequencer.
package xadc_pkg;

  localparam int RES_W      = 12;
  localparam int DAC_CH_LSB = 12;
  localparam int DAC_CH_W   = 2;

  typedef logic [RES_W-1:0] result_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_EOC,
    S_READ,
    S_WAIT_DRDY,
    S_STORE,
    S_DAC_REQ,
    S_NEXT
  } state_t;

  // DRP addresses of VAUX channels 0..3 as wired on the board
  localparam logic [6:0] CH_ADDR [4] = '{7'h1E, 7'h17, 7'h1F, 7'h16};

  // Next enabled channel after cur (wrapping); cur itself only if it is the sole one
  function automatic logic [1:0] next_ch(input logic [1:0] cur, input logic [3:0] en);
    logic [1:0] idx;
    next_ch = cur;
    for (int k = 4; k >= 1; k--) begin
      idx = cur + 2'(k);
      if (en[idx]) next_ch = idx;
    end
  endfunction

  function automatic logic [15:0] dac_pack(input logic [1:0] ch, input result_t r);
    dac_pack = '0;
    dac_pack[DAC_CH_LSB +: DAC_CH_W] = ch;
    dac_pack[RES_W-1:0] = r;
  endfunction

endpackage

// File: rtl/xadc_scan_ctrl_if.sv
// DRP read bus and DAC send/done handshake seen by the scan sequencer.
interface xadc_scan_ctrl_if;
  logic        eoc;
  logic        drdy;
  logic [15:0] do_in;
  logic [6:0]  daddr;
  logic        den;
  logic [15:0] dac_word;
  logic        dac_send;
  logic        dac_done;

  modport master (
    input  eoc, drdy, do_in, dac_done,
    output daddr, den, dac_word, dac_send
  );

  modport slave (
    output eoc, drdy, do_in, dac_done,
    input  daddr, den, dac_word, dac_send
  );
endinterface

// File: rtl/xadc_avg.sv
// Per-channel sample accumulator: emits sum >> AVG_LOG2 on every 2^AVG_LOG2-th sample.
module xadc_avg
  import xadc_pkg::*;
#(
  parameter int AVG_LOG2 = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    add,
  input  result_t sample,
  output logic    done,
  output result_t result
);

  // Wide enough to hold 2^AVG_LOG2 full-scale samples without wrapping
  localparam int ACC_W = RES_W + AVG_LOG2;

  logic [ACC_W-1:0]    acc_reg;
  logic [ACC_W-1:0]    sum;
  logic [AVG_LOG2-1:0] cnt_reg;

  assign sum    = acc_reg + ACC_W'(sample);
  assign done   = add && (cnt_reg == '1);
  assign result = sum[ACC_W-1:AVG_LOG2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_reg <= '0;
      cnt_reg <= '0;
    end else if (add) begin
      if (done) begin
        acc_reg <= '0;
        cnt_reg <= '0;
      end else begin
        acc_reg <= sum;
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/xadc_scan_ctrl.sv
// Round-robin XADC DRP scanner feeding the SPI DAC path.
// Define XADC_AVG_EN to average 2^AVG_LOG2 samples per channel before each result.
module xadc_scan_ctrl
  import xadc_pkg::*;
#(
  parameter int DRDY_TIMEOUT = 15,
  parameter int AVG_LOG2     = 4,
  parameter int NOISE_FLOOR  = 7
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [3:0]              ch_en,
  input  logic [1:0]              rd_sel,
  output result_t                 rd_data,
  output logic [3:0]              valid,
  output logic                    err,
  xadc_scan_ctrl_if.master        bus
);

  localparam int TW = $clog2(DRDY_TIMEOUT + 1);

  if (AVG_LOG2 < 1 || AVG_LOG2 > 16) begin : g_avg_range
    $error("AVG_LOG2 must be in 1..16");
  end

  state_t        state_reg;
  logic [1:0]    cur_reg;
  logic [TW-1:0] timer_reg;
  result_t       sample_reg;
  result_t       results_reg [4];
  logic [6:0]    daddr_reg;
  logic          den_reg;
  logic [15:0]   dac_word_reg;
  logic          dac_send_reg;
  logic [3:0]    valid_reg;
  logic          err_reg;

  logic    store_hit;
  result_t store_val;
  result_t cond_val;

`ifdef XADC_AVG_EN
  logic [3:0] avg_add;
  logic [3:0] avg_done;
  result_t    avg_res [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_avg
    assign avg_add[gi] = (state_reg == S_STORE) && (cur_reg == 2'(gi));
    xadc_avg #(.AVG_LOG2(AVG_LOG2)) u_avg (
      .clk    (clk),
      .rst    (rst),
      .add    (avg_add[gi]),
      .sample (sample_reg),
      .done   (avg_done[gi]),
      .result (avg_res[gi])
    );
  end

  assign store_hit = avg_done[cur_reg];
  assign store_val = avg_res[cur_reg];
`else
  assign store_hit = 1'b1;
  assign store_val = sample_reg;
`endif

  assign cond_val = (store_val <= RES_W'(NOISE_FLOOR)) ? '0 : store_val;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      cur_reg      <= '0;
      timer_reg    <= '0;
      sample_reg   <= '0;
      for (int i = 0; i < 4; i++) results_reg[i] <= '0;
      daddr_reg    <= CH_ADDR[0];
      den_reg      <= 1'b0;
      dac_word_reg <= '0;
      dac_send_reg <= 1'b0;
      valid_reg    <= '0;
      err_reg      <= 1'b0;
    end else begin
      den_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (ch_en != 4'b0000) begin
            cur_reg   <= next_ch(2'd3, ch_en);
            state_reg <= S_WAIT_EOC;
          end
        end
        S_WAIT_EOC: begin
          if (bus.eoc) begin
            den_reg   <= 1'b1;
            daddr_reg <= CH_ADDR[cur_reg];
            state_reg <= S_READ;
          end
        end
        S_READ: begin
          timer_reg <= '0;
          state_reg <= S_WAIT_DRDY;
        end
        S_WAIT_DRDY: begin
          if (bus.drdy) begin
            sample_reg <= bus.do_in[15:4];
            state_reg  <= S_STORE;
          end else if (timer_reg == TW'(DRDY_TIMEOUT - 1)) begin
            err_reg   <= 1'b1;
            state_reg <= S_NEXT;
          end else begin
            timer_reg <= timer_reg + TW'(1);
          end
        end
        S_STORE: begin
          if (store_hit) begin
            results_reg[cur_reg] <= cond_val;
            valid_reg[cur_reg]   <= 1'b1;
            dac_word_reg         <= dac_pack(cur_reg, cond_val);
            dac_send_reg         <= 1'b1;
            state_reg            <= S_DAC_REQ;
          end else begin
            state_reg <= S_NEXT;
          end
        end
        S_DAC_REQ: begin
          if (bus.dac_done) begin
            dac_send_reg <= 1'b0;
            state_reg    <= S_NEXT;
          end
        end
        S_NEXT: begin
          if (ch_en == 4'b0000) begin
            state_reg <= S_IDLE;
          end else begin
            cur_reg   <= next_ch(cur_reg, ch_en);
            state_reg <= S_WAIT_EOC;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign rd_data      = results_reg[rd_sel];
  assign valid        = valid_reg;
  assign err          = err_reg;
  assign bus.daddr    = daddr_reg;
  assign bus.den      = den_reg;
  assign bus.dac_word = dac_word_reg;
  assign bus.dac_send = dac_send_reg;

endmodule

// File: tb/tb_xadc_scan_ctrl.sv
// Directed bench for xadc_scan_ctrl: idle, round-robin scan, noise floor, timeout, async reset.
module tb_xadc_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  ch_en;
  logic [1:0]  rd_sel;
  logic [11:0] rd_data;
  logic [3:0]  valid;
  logic        err;

  int checks = 0;
  int errors = 0;

  xadc_scan_ctrl_if bus_if ();

  xadc_scan_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .ch_en   (ch_en),
    .rd_sel  (rd_sel),
    .rd_data (rd_data),
    .valid   (valid),
    .err     (err),
    .bus     (bus_if)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One channel visit: eoc, den, drdy two cycles later, then DAC handshake
  task automatic scan(input logic [6:0] addr, input logic [15:0] din, input logic [15:0] word,
                      input int hold, input bit abort);
    bus_if.eoc = 1'b1;
    tick;
    bus_if.eoc = 1'b0;
    check("den_pulse", 32'(bus_if.den), 32'd1);
    check("daddr", 32'(bus_if.daddr), 32'(addr));
    tick;
    check("den_single", 32'(bus_if.den), 32'd0);
    tick;
    tick;
    bus_if.do_in = din;
    bus_if.drdy  = 1'b1;
    tick;
    bus_if.drdy  = 1'b0;
    bus_if.do_in = 16'h0000;
    check("send_in_store", 32'(bus_if.dac_send), 32'd0);
    tick;
    check("dac_send", 32'(bus_if.dac_send), 32'd1);
    check("dac_word", 32'(bus_if.dac_word), 32'(word));
    for (int h = 0; h < hold; h++) begin
      tick;
      check("dac_send_hold", 32'(bus_if.dac_send), 32'd1);
      check("dac_word_hold", 32'(bus_if.dac_word), 32'(word));
    end
    $display("scan daddr=%02h do_in=%04h dac_word=%04h", addr, din, bus_if.dac_word);
    if (abort) return;
    bus_if.dac_done = 1'b1;
    tick;
    bus_if.dac_done = 1'b0;
    check("dac_send_drop", 32'(bus_if.dac_send), 32'd0);
    tick;
  endtask

`ifdef XADC_AVG_EN
  task automatic scan_acc(input logic [15:0] din);
    bus_if.eoc = 1'b1;
    tick;
    bus_if.eoc = 1'b0;
    check("acc_den", 32'(bus_if.den), 32'd1);
    tick;
    tick;
    tick;
    bus_if.do_in = din;
    bus_if.drdy  = 1'b1;
    tick;
    bus_if.drdy  = 1'b0;
    tick;
    check("acc_no_send", 32'(bus_if.dac_send), 32'd0);
    $display("acc do_in=%04h dac_send=%0d", din, bus_if.dac_send);
    tick;
  endtask
`endif

  initial begin
    rst             = 1'b1;
    ch_en           = 4'b0000;
    rd_sel          = 2'd0;
    bus_if.eoc      = 1'b0;
    bus_if.drdy     = 1'b0;
    bus_if.do_in    = 16'h0000;
    bus_if.dac_done = 1'b0;
    repeat (2) tick;

    check("rst_daddr", 32'(bus_if.daddr), 32'h1E);
    check("rst_den", 32'(bus_if.den), 32'd0);
    check("rst_dac_send", 32'(bus_if.dac_send), 32'd0);
    check("rst_dac_word", 32'(bus_if.dac_word), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    rst = 1'b0;

    // No channels enabled: eoc must never start a read
    for (int i = 0; i < 8; i++) begin
      bus_if.eoc = (i % 2 == 0);
      tick;
      check("idle_den", 32'(bus_if.den), 32'd0);
      check("idle_dac_send", 32'(bus_if.dac_send), 32'd0);
    end
    bus_if.eoc = 1'b0;

`ifdef XADC_AVG_EN
    ch_en = 4'b0001;
    tick;
    for (int i = 0; i < 8; i++) scan_acc(16'h1000);
    for (int i = 0; i < 7; i++) scan_acc(16'h2000);
    check("avg_valid_pending", 32'(valid), 32'd0);
    scan(7'h1E, 16'h2000, 16'h0180, 0, 1'b0);
    check("avg_valid", 32'(valid), 32'h1);
    rd_sel = 2'd0;
    #1;
    check("avg_rd_data", 32'(rd_data), 32'h180);
`else
    ch_en = 4'b1001;
    tick;
    scan(7'h1E, 16'h8000, 16'h0800, 3, 1'b0);
    scan(7'h16, 16'h8000, 16'h3800, 0, 1'b0);
    check("valid_1001", 32'(valid), 32'h9);
    rd_sel = 2'd3;
    #1;
    check("rd_data_ch3", 32'(rd_data), 32'h800);

    // Noise floor boundary: 7 is squashed, 8 passes through
    scan(7'h1E, 16'h0070, 16'h0000, 0, 1'b0);
    scan(7'h16, 16'h0080, 16'h3008, 0, 1'b0);
    rd_sel = 2'd0;
    #1;
    check("rd_data_floor", 32'(rd_data), 32'h000);
    rd_sel = 2'd3;
    #1;
    check("rd_data_above", 32'(rd_data), 32'h008);

    // DRDY timeout on channel 0
    bus_if.eoc = 1'b1;
    tick;
    bus_if.eoc = 1'b0;
    check("to_den", 32'(bus_if.den), 32'd1);
    check("to_daddr", 32'(bus_if.daddr), 32'h1E);
    repeat (15) tick;
    check("to_err_before", 32'(err), 32'd0);
    tick;
    check("to_err", 32'(err), 32'd1);
    check("to_no_send", 32'(bus_if.dac_send), 32'd0);
    $display("timeout err=%0d", err);
    tick;
    bus_if.do_in = 16'hFFF0;
    bus_if.drdy  = 1'b1;
    tick;
    bus_if.drdy  = 1'b0;
    bus_if.do_in = 16'h0000;
    tick;
    check("late_drdy_send", 32'(bus_if.dac_send), 32'd0);
    rd_sel = 2'd0;
    #1;
    check("late_drdy_rd", 32'(rd_data), 32'h000);
    scan(7'h16, 16'hC000, 16'h3C00, 0, 1'b0);
    check("err_sticky", 32'(err), 32'd1);

    // Asynchronous reset mid-handshake
    scan(7'h1E, 16'h1230, 16'h0123, 1, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_dac_send", 32'(bus_if.dac_send), 32'd0);
    check("arst_dac_word", 32'(bus_if.dac_word), 32'd0);
    check("arst_daddr", 32'(bus_if.daddr), 32'h1E);
    check("arst_valid", 32'(valid), 32'd0);
    check("arst_err", 32'(err), 32'd0);
    check("arst_rd_data", 32'(rd_data), 32'd0);
    $display("async reset dac_send=%0d", bus_if.dac_send);
    tick;
    rst = 1'b0;
    tick;
    scan(7'h1E, 16'h4560, 16'h0456, 0, 1'b0);
    check("resume_valid", 32'(valid), 32'h1);
    scan(7'h16, 16'h7FF0, 16'h37FF, 0, 1'b0);
    check("resume_valid2", 32'(valid), 32'h9);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/xadc_scan_ctrl.md
# xadc_scan_ctrl

Sequencer for the XADC dynamic reconfiguration port (DRP) that scans the four auxiliary channels selected by the board switches in round-robin order. On each end-of-conversion it reads the channel result, conditions it, and stores a per-channel 12-bit value. It then hands each new value to the SPI DAC path through a send/done handshake. It sits between `xadc_wiz_0` and the `spi_ctrl`/`spi_shift` pair, and replaces the free-running address/`sel` logic in the top level.

## Interface
Parameters:
- DRDY_TIMEOUT, 15: cycles allowed from `den` pulse to `drdy` before the read is abandoned.
- AVG_LOG2, 4: log2 of the number of samples averaged per channel (used only when averaging is compiled in).
- NOISE_FLOOR, 7: conditioned results ≤ this value are forced to 0.

Ports:
- clk  in  1  DRP clock, 100 MHz; the single clock of the block.
- rst  in  1  asynchronous, active-high reset.
- ch_en  in  4  channel enable mask (switches); bit i enables channel i.
- eoc  in  1  XADC end-of-conversion pulse.
- drdy  in  1  XADC DRP data-ready pulse.
- do_in  in  16  XADC DRP read data; the result is in bits [15:4].
- daddr  out  7  DRP address of the current channel.
- den  out  1  DRP enable, one-cycle pulse.
- rd_sel  in  2  readback channel select.
- rd_data  out  12  stored result of channel `rd_sel` (combinational mux of registers).
- valid  out  4  per-channel "result written since reset" flags.
- err  out  1  sticky DRDY timeout flag.
- dac_word  out  16  DAC word: {2'b00, ch[1:0], result[11:0]}.
- dac_send  out  1  request to the SPI controller; held until `dac_done`.
- dac_done  in  1  SPI controller transfer complete, one-cycle pulse.

## Operation
- Channel address map (channel 0..3): 0x1E, 0x17, 0x1F, 0x16.
- States:
  - IDLE: if `ch_en`==0, stay; otherwise `cur` is set to the lowest enabled channel and the state goes to WAIT_EOC.
  - WAIT_EOC: on `eoc`, go to READ.
  - READ: `den`=1 for exactly one cycle, with `daddr` set to ADDR[cur]; go to WAIT_DRDY and clear the timer.
  - WAIT_DRDY: on `drdy`, latch `do_in[15:4]` and go to STORE. If the timer reaches DRDY_TIMEOUT, set `err` and go to NEXT without storing.
  - STORE: condition the sample and update the accumulator/result. If a result is produced, go to DAC_REQ; otherwise go to NEXT.
  - DAC_REQ: assert `dac_send` with `dac_word`; on `dac_done`, deassert `dac_send` and go to NEXT.
  - NEXT: `cur` becomes the next enabled channel after `cur`, wrapping 3→0. If `cur` is the only enabled channel, `cur` is unchanged. Go to WAIT_EOC, or to IDLE if `ch_en`==0.
- `ch_en` is sampled only in IDLE and NEXT. A channel disabled mid-read completes its read.
- Conditioning: result = sample, or 0 if sample ≤ NOISE_FLOOR.
- `dac_word` and `daddr` are stable while `dac_send`/`den` are high.
- `eoc` pulses that arrive outside WAIT_EOC are ignored (no queuing).
- `drdy` outside WAIT_DRDY is ignored.
- A `dac_done` that arrives in the same cycle `dac_send` rises is accepted.

## Timing
- Reset values:
  - `daddr`=0x1E
  - `den`=0
  - `dac_send`=0
  - `dac_word`=0
  - `valid`=0
  - `err`=0
  - all results, accumulators and counters = 0
  - state = IDLE
- Reset is asynchronous at any point, including mid-DAC handshake; `dac_send` drops immediately.
- Latency from `eoc` to `den` is 1 cycle. From `drdy` to the result register is 2 cycles (latch, then STORE). `dac_send` rises in the cycle after STORE.
- Minimum scan cost per channel is 5 cycles plus the `drdy` wait plus the DAC handshake.

## Configuration
- XADC_AVG_EN defined:
  - Each channel has a (12+AVG_LOG2)-bit accumulator and a sample counter.
  - The result and DAC request are produced only on the 2^AVG_LOG2-th sample of that channel. Result = sum >> AVG_LOG2, conditioned after the shift.
  - After that, the accumulator and counter clear.
  - Accumulators are never truncated: the width is sized to hold 2^AVG_LOG2 samples.
- XADC_AVG_EN undefined:
  - Every stored sample produces a result and a DAC request.
  - No accumulators are synthesised.

## Structure
- Package `xadc_pkg`:
  - the state enum
  - the channel address array
  - the DAC word field positions
  - the 12-bit result type
- One sub-module `xadc_avg`: a per-channel accumulator/counter, instantiated ×4 under XADC_AVG_EN.

## Test plan
- `ch_en`=4'b0000, `eoc` pulsing → `den` never asserts, state stays IDLE, `dac_send`=0.
- `ch_en`=4'b1001, `drdy` returns 0x8000 (sample 0x800), averaging off:
  - `den` addresses alternate 0x1E, 0x16, 0x1E.
  - `dac_word`=0x0800, then 0x3800.
  - `valid`=4'b1001.
- `do_in`=0x0070 (sample 7) → `rd_data`=0 and `dac_word`[11:0]=0. `do_in`=0x0080 → 0x008.
- No `drdy` for 15 cycles after `den` → `err`=1, no store, no DAC request, and the scan moves to the next channel.
- XADC_AVG_EN, AVG_LOG2=4, channel 0 only, samples 0x100 ×8 then 0x200 ×8 → exactly one `dac_send` after the 16th sample, with `dac_word`=0x0180.
- Assert `rst` while `dac_send`=1 → all outputs return to their reset values without a clock edge; normal scanning resumes after release.
